planificador_hash: RTL

//  Job scheduler for one micro_ucr_hash core. Queues mining jobs (bloque_datos + target) in a FIFO
//  and sequences the core's inicio/terminado handshake, one job at a time. Returns each bounty on a

---
 rtl/planificador_hash_if.sv | 33 +++
 rtl/planificador_hash.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/planificador_hash_if.sv
// Job, core and result handshakes of the micro_ucr_hash scheduler.
// master = scheduler side, slave = job source / core / result consumer side.
interface planificador_hash_if;
  localparam int unsigned ANCHO_BLOQUE = 96;
  localparam int unsigned ANCHO_TARGET = 8;
  localparam int unsigned ANCHO_BOUNTY = 124;

  logic                    job_valid;
  logic                    job_ready;
  logic [ANCHO_BLOQUE-1:0] job_bloque;
  logic [ANCHO_TARGET-1:0] job_target;

  logic                    inicio;
  logic [ANCHO_BLOQUE-1:0] bloque_datos;
  logic [ANCHO_TARGET-1:0] target;
  logic                    terminado;
  logic [ANCHO_BOUNTY-1:0] bounty;

  logic                    res_valid;
  logic                    res_ready;
  logic [ANCHO_BOUNTY-1:0] res_bounty;
  logic                    res_timeout;

  modport master (
    input  job_valid, job_bloque, job_target, terminado, bounty, res_ready,
    output job_ready, inicio, bloque_datos, target, res_valid, res_bounty, res_timeout
  );

  modport slave (
    output job_valid, job_bloque, job_target, terminado, bounty, res_ready,
    input  job_ready, inicio, bloque_datos, target, res_valid, res_bounty, res_timeout
  );
endinterface

// File: rtl/planificador_hash.sv
// Job scheduler for one micro_ucr_hash core: job FIFO, inicio/terminado sequencing, timeout abort.
// Optional performance counters (ciclos_trabajo, trabajos_ok) are built when PERF_CNT_EN is defined.
module planificador_hash #(
  parameter int unsigned PROF_FIFO      = 4,
  parameter int unsigned TIMEOUT_CICLOS = 4096,
  parameter int unsigned ANCHO_TMO      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  planificador_hash_if.master  bus,
  output logic                 ocupado,
  output logic [31:0]          ciclos_trabajo,
  output logic [15:0]          trabajos_ok
);
  localparam int unsigned ANCHO_BLOQUE = 96;
  localparam int unsigned ANCHO_TARGET = 8;
  localparam int unsigned ANCHO_BOUNTY = 124;
  localparam int unsigned ANCHO_JOB    = ANCHO_BLOQUE + ANCHO_TARGET;
  localparam int unsigned ANCHO_PTR    = (PROF_FIFO > 1) ? $clog2(PROF_FIFO) : 1;
  localparam int unsigned ANCHO_CNT    = ANCHO_PTR + 1;
  localparam int unsigned ANCHO_PERF   = 32;
  localparam int unsigned ANCHO_OK     = 16;

  localparam logic [ANCHO_CNT-1:0] LLENO  = ANCHO_CNT'(PROF_FIFO);
  localparam bit                   TMO_EN = (TIMEOUT_CICLOS != 0);
  localparam logic [ANCHO_TMO-1:0] TMO_LIM =
    ANCHO_TMO'((TIMEOUT_CICLOS == 32'd0) ? 32'd0 : TIMEOUT_CICLOS - 32'd1);

  typedef enum logic [2:0] {
    REPOSO  = 3'd0,
    CARGA   = 3'd1,
    ESPERA  = 3'd2,
    ENTREGA = 3'd3,
    PAUSA   = 3'd4
  } estado_t;

  estado_t estado, estado_sig;

  logic [ANCHO_JOB-1:0] mem [PROF_FIFO];
  logic [ANCHO_PTR-1:0] wr_ptr, rd_ptr;
  logic [ANCHO_CNT-1:0] cuenta, cuenta_sig;
  logic                 push, pop;
  logic                 fin_ok, fin_tmo;
  logic [ANCHO_TMO-1:0] cnt_tmo;

  assign push = bus.job_valid && bus.job_ready;
  assign pop  = (estado == REPOSO) && (cuenta != '0);

  // FIFO occupancy; push and pop together leave the count unchanged
  always_comb begin
    cuenta_sig = cuenta;
    if (push && !pop) begin
      cuenta_sig = cuenta + ANCHO_CNT'(1);
    end else if (!push && pop) begin
      cuenta_sig = cuenta - ANCHO_CNT'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      cuenta        <= '0;
      bus.job_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + ANCHO_PTR'(1);
      if (pop)  rd_ptr <= rd_ptr + ANCHO_PTR'(1);
      cuenta        <= cuenta_sig;
      bus.job_ready <= (cuenta_sig != LLENO);
    end
  end

  // Job storage needs no reset: the pointers define what is valid
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.job_target, bus.job_bloque};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado <= REPOSO;
    end else begin
      estado <= estado_sig;
    end
  end

  always_comb begin
    estado_sig = estado;
    fin_ok     = 1'b0;
    fin_tmo    = 1'b0;
    case (estado)
      REPOSO:  if (cuenta != '0) estado_sig = CARGA;
      CARGA:   estado_sig = ESPERA;
      ESPERA: begin
        if (bus.terminado) begin
          fin_ok     = 1'b1;
          estado_sig = ENTREGA;
        end else if (TMO_EN && (cnt_tmo == TMO_LIM)) begin
          fin_tmo    = 1'b1;
          estado_sig = ENTREGA;
        end
      end
      ENTREGA: if (bus.res_ready) estado_sig = PAUSA;
      PAUSA:   estado_sig = REPOSO;
      default: estado_sig = REPOSO;
    endcase
  end

  // Registered core/result outputs follow the next state so they change on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.inicio       <= 1'b0;
      bus.bloque_datos <= '0;
      bus.target       <= '0;
      bus.res_valid    <= 1'b0;
      bus.res_bounty   <= '0;
      bus.res_timeout  <= 1'b0;
      ocupado          <= 1'b0;
      cnt_tmo          <= '0;
    end else begin
      bus.inicio    <= (estado_sig == ESPERA);
      bus.res_valid <= (estado_sig == ENTREGA);
      ocupado       <= (estado_sig != REPOSO);
      if (pop) begin
        {bus.target, bus.bloque_datos} <= mem[rd_ptr];
      end
      if (estado == CARGA) begin
        cnt_tmo <= '0;
      end else if (estado == ESPERA) begin
        cnt_tmo <= cnt_tmo + ANCHO_TMO'(1);
      end
      if (fin_ok) begin
        bus.res_bounty  <= bus.bounty;
        bus.res_timeout <= 1'b0;
      end else if (fin_tmo) begin
        bus.res_bounty  <= '0;
        bus.res_timeout <= 1'b1;
      end
    end
  end

`ifdef PERF_CNT_EN
  logic [ANCHO_PERF-1:0] cnt_espera;

  // ESPERA length includes the cycle in which terminado or the timeout is seen
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_espera     <= '0;
      ciclos_trabajo <= '0;
      trabajos_ok    <= '0;
    end else begin
      if (estado == CARGA) begin
        cnt_espera <= '0;
      end else if (estado == ESPERA) begin
        cnt_espera <= cnt_espera + ANCHO_PERF'(1);
      end
      if (fin_ok || fin_tmo) begin
        ciclos_trabajo <= cnt_espera + ANCHO_PERF'(1);
      end
      if (bus.res_valid && bus.res_ready && !bus.res_timeout) begin
        trabajos_ok <= trabajos_ok + ANCHO_OK'(1);
      end
    end
  end
`else
  assign ciclos_trabajo = '0;
  assign trabajos_ok    = '0;
`endif

endmodule
